fp_pipe_skid_buffer: RTL and testbench
======================================

# fp_pipe_skid_buffer

Two-entry elastic buffer placed directly downstream of a pipeline data register. It converts the register's valid/data output into a stall-based handshake for the next floating-point operator stage. Because its upstream stall is a registered-state decode, it breaks the combinational stall path between generated pipeline stages. It runs at full throughput (one transfer per cycle) and adds one cycle of latency.

## Interface
Parameters:
- DataWidth, 32, width of the data word carried through the buffer.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  synchronous clear of buffer contents; lower priority than rst.
- in_vld  input  1  upstream data valid (driven by the upstream register's ready flag).
- in_data  input  DataWidth  upstream data word.
- in_stall  output  1  asserted: upstream must hold in_data/in_vld; no transfer this cycle.
- out_vld  output  1  out_data holds a valid word.
- out_data  output  DataWidth  head word of the buffer.
- out_stall  input  1  downstream stall; asserted: head is not consumed this cycle.
- occupancy  output  2  number of held words, 0..2.

## Operation
- Push: in_vld && !in_stall. Pop: out_vld && !out_stall.
- Storage: head register drives out_data; skid register holds the second word.
- States: EMPTY (occupancy 0), HALF (1), FULL (2).
  - EMPTY: push -> HALF, head <= in_data. Otherwise stay in EMPTY.
  - HALF, push && pop -> HALF, head <= in_data.
  - HALF, push only -> FULL, skid <= in_data.
  - HALF, pop only -> EMPTY.
  - HALF, neither -> hold.
  - FULL: push is impossible (in_stall = 1). Pop -> HALF, head <= skid. No pop -> hold.
- Output decodes (state only, no input-to-output combinational path):
  - out_vld = (state != EMPTY)
  - in_stall = (state == FULL)
  - occupancy = state count
- in_vld while in_stall = 1: ignored, nothing captured. in_data is don't-care when in_vld = 0.
- Data words are never reordered, duplicated or dropped, except by flush or rst.
- flush: next state EMPTY. A push or pop in the same cycle is discarded, with no capture. Data registers are not required to clear.
- rst, synchronous: state EMPTY, head = 0, skid = 0. Outputs after reset: out_vld 0, out_data 0, in_stall 0, occupancy 0. Reset mid-operation discards all held words.

## Timing
- Latency: a word pushed in cycle N (buffer EMPTY) is on out_data with out_vld = 1 in cycle N+1.
- Throughput: with out_stall held 0, one push and one pop per cycle indefinitely; state stays HALF.
- in_stall rises the cycle after a HALF push-without-pop. It falls the cycle after a FULL pop.
- A stall arriving on out_stall reaches in_stall at earliest one cycle later. The skid register absorbs the word in flight.
- out_data is stable while out_vld = 1 && out_stall = 1.
- flush and rst take effect at the next rising edge. Outputs reflect EMPTY from that edge.

## Structure
- Shared pipeline package holds the state encoding constants ST_EMPTY = 2'd0, ST_HALF = 2'd1, ST_FULL = 2'd2. Encoding equals occupancy, so occupancy = state.
- No sub-module: the head and skid registers are inline with their enables, and next-state logic is a single case on state.

## Test plan
- Reset then idle: assert rst for 2 cycles -> out_vld 0, out_data 0, in_stall 0, occupancy 0. Release with in_vld 0 -> values hold.
- Streaming: out_stall 0, push 0x11, 0x22, 0x33 on consecutive cycles -> out_data shows 0x11, 0x22, 0x33 one cycle after each push. in_stall stays 0 and occupancy stays 1.
- Fill: out_stall 1, push 0xA and 0xB -> occupancy 2, in_stall 1. Next in_vld with 0xC is not captured. Release out_stall -> pops in order 0xA, 0xB, then 0xC is accepted.
- Drain from FULL: in FULL, out_stall 0, in_vld 0 -> occupancy goes 2 -> 1 -> 0, out_vld falls after the second pop, in_stall falls one cycle after the first pop.
- Flush collision: in HALF, assert flush with in_vld = 1 (0x55) and out_stall = 0 -> next cycle EMPTY, out_vld 0, 0x55 is never output.
- Reset mid-stream: in FULL, assert rst -> next cycle EMPTY with all outputs at reset values. A subsequent push of 0x77 appears alone on out_data.

Source files
------------

// File: rtl/fp_pipe_skid_buffer_pkg.sv
// Shared pipeline definitions for the skid buffer stage.
// The state encoding doubles as the occupancy count, so the
// occupancy output is simply the state register.
package fp_pipe_skid_buffer_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/fp_pipe_skid_buffer.sv
// Two-entry elastic buffer between a pipeline data register and the
// next floating-point operator stage. The upstream stall comes only
// from registered state, which breaks the combinational stall chain
// between stages. Head drives out_data; skid catches the word in
// flight when the downstream stalls.
module fp_pipe_skid_buffer
  import fp_pipe_skid_buffer_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_vld,
  input  logic [DataWidth-1:0] in_data,
  output logic                 in_stall,
  output logic                 out_vld,
  output logic [DataWidth-1:0] out_data,
  input  logic                 out_stall,
  output logic [1:0]           occupancy
);

  state_t               state_q;
  state_t               state_d;
  logic [DataWidth-1:0] head_q;
  logic [DataWidth-1:0] skid_q;
  logic                 push;
  logic                 pop;
  logic                 head_en;
  logic                 head_from_skid;
  logic                 skid_en;

  // Outputs decode state only, so no input reaches an output combinationally.
  assign out_vld   = (state_q != ST_EMPTY);
  assign in_stall  = (state_q == ST_FULL);
  assign occupancy = state_q;
  assign out_data  = head_q;

  assign push = in_vld && !in_stall;
  assign pop  = out_vld && !out_stall;

  // Next-state and register-enable decode; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    head_en        = 1'b0;
    head_from_skid = 1'b0;
    skid_en        = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_HALF;
          head_en = 1'b1;
        end
      end
      ST_HALF: begin
        if (push && pop) begin
          head_en = 1'b1;
        end else if (push) begin
          state_d = ST_FULL;
          skid_en = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d        = ST_HALF;
          head_en        = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_d        = ST_EMPTY;
      head_en        = 1'b0;
      head_from_skid = 1'b0;
      skid_en        = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Head and skid data registers, cleared on reset and loaded by their enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (head_en) begin
        head_q <= head_from_skid ? skid_q : in_data;
      end
      if (skid_en) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_fp_pipe_skid_buffer.sv
// Directed self-checking bench for fp_pipe_skid_buffer.
module tb_fp_pipe_skid_buffer;

  localparam int DataWidth = 32;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 in_vld;
  logic [DataWidth-1:0] in_data;
  logic                 in_stall;
  logic                 out_vld;
  logic [DataWidth-1:0] out_data;
  logic                 out_stall;
  logic [1:0]           occupancy;

  int compared   = 0;
  int mismatched = 0;

  fp_pipe_skid_buffer #(.DataWidth(DataWidth)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_vld    (in_vld),
    .in_data   (in_data),
    .in_stall  (in_stall),
    .out_vld   (out_vld),
    .out_data  (out_data),
    .out_stall (out_stall),
    .occupancy (occupancy)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Checks all four observable outputs against hand-computed values.
  task automatic checkAll(input string tag, input logic vld, input logic [31:0] data,
                          input logic stall, input logic [1:0] occ);
    checkOutput({tag, ".out_vld"}, {31'd0, out_vld}, {31'd0, vld});
    if (vld) checkOutput({tag, ".out_data"}, out_data, data);
    checkOutput({tag, ".in_stall"}, {31'd0, in_stall}, {31'd0, stall});
    checkOutput({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
  endtask

  // Drives one cycle of inputs, then waits past the next rising edge.
  task automatic applyStimulus(input logic r, input logic f, input logic v,
                               input logic [31:0] d, input logic s);
    rst       = r;
    flush     = f;
    in_vld    = v;
    in_data   = d;
    out_stall = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_vld = 1'b0; in_data = '0; out_stall = 1'b0;

    // Reset for two cycles, then idle.
    applyStimulus(1, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 0);
    checkAll("reset", 0, 32'h0, 0, 2'd0);
    checkOutput("reset.out_data", out_data, 32'h0);
    applyStimulus(0, 0, 0, 32'hDEAD, 0);
    checkAll("idle", 0, 32'h0, 0, 2'd0);
    checkOutput("idle.out_data", out_data, 32'h0);

    // Streaming at full throughput.
    applyStimulus(0, 0, 1, 32'h11, 0);
    checkAll("stream0", 1, 32'h11, 0, 2'd1);
    applyStimulus(0, 0, 1, 32'h22, 0);
    checkAll("stream1", 1, 32'h22, 0, 2'd1);
    applyStimulus(0, 0, 1, 32'h33, 0);
    checkAll("stream2", 1, 32'h33, 0, 2'd1);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkAll("stream_end", 0, 32'h0, 0, 2'd0);

    // Fill under downstream stall; third word must be refused.
    applyStimulus(0, 0, 1, 32'hA, 1);
    checkAll("fill0", 1, 32'hA, 0, 2'd1);
    applyStimulus(0, 0, 1, 32'hB, 1);
    checkAll("fill1", 1, 32'hA, 1, 2'd2);
    applyStimulus(0, 0, 1, 32'hC, 1);
    checkAll("fill_refused", 1, 32'hA, 1, 2'd2);
    applyStimulus(0, 0, 1, 32'hC, 0);
    checkAll("fill_pop_a", 1, 32'hB, 0, 2'd1);
    applyStimulus(0, 0, 1, 32'hC, 0);
    checkAll("fill_pop_b", 1, 32'hC, 0, 2'd1);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkAll("fill_empty", 0, 32'h0, 0, 2'd0);

    // Drain from FULL with no new input.
    applyStimulus(0, 0, 1, 32'h1, 1);
    applyStimulus(0, 0, 1, 32'h2, 1);
    checkAll("drain_full", 1, 32'h1, 1, 2'd2);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkAll("drain1", 1, 32'h2, 0, 2'd1);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkAll("drain0", 0, 32'h0, 0, 2'd0);

    // Flush collides with a push and a pop in HALF.
    applyStimulus(0, 0, 1, 32'h44, 1);
    checkAll("flush_half", 1, 32'h44, 0, 2'd1);
    applyStimulus(0, 1, 1, 32'h55, 0);
    checkAll("flush", 0, 32'h0, 0, 2'd0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkAll("flush_after", 0, 32'h0, 0, 2'd0);

    // Reset while FULL, then a fresh word.
    applyStimulus(0, 0, 1, 32'h66, 1);
    applyStimulus(0, 0, 1, 32'h67, 1);
    checkAll("rst_full", 1, 32'h66, 1, 2'd2);
    applyStimulus(1, 0, 0, 32'h0, 1);
    checkAll("rst_mid", 0, 32'h0, 0, 2'd0);
    checkOutput("rst_mid.out_data", out_data, 32'h0);
    applyStimulus(0, 0, 1, 32'h77, 1);
    checkAll("rst_push", 1, 32'h77, 0, 2'd1);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkAll("rst_hold", 1, 32'h77, 0, 2'd1);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkAll("rst_drain", 0, 32'h0, 0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
